// File: rtl/neosd_pkg.sv
// Shared constants and types for the neosd DMA engine: neosd register map,
// DMA register map, CTRL bit positions and the transfer FSM state encoding.
package neosd_pkg;

    // neosd SD controller register offsets (relative to SD_BASE)
    localparam logic [31:0] NEOSD_CTRL_OFF = 32'h0000_0000;
    localparam logic [31:0] NEOSD_DATA_OFF = 32'h0000_0014;
    // DAT DATA flag in the neosd CTRL register
    localparam int unsigned NEOSD_FLAG_BIT = 17;

    // DMA slave register offsets (decoded on adr[3:0])
    localparam logic [3:0] DMA_CTRL_OFF  = 4'h0;
    localparam logic [3:0] DMA_ADDR_OFF  = 4'h4;
    localparam logic [3:0] DMA_COUNT_OFF = 4'h8;
    localparam logic [3:0] DMA_BASE_OFF  = 4'hC;

    // DMA CTRL bit positions
    localparam int unsigned CTRL_START  = 0;
    localparam int unsigned CTRL_DIR    = 1;
    localparam int unsigned CTRL_IRQ_EN = 2;
    localparam int unsigned CTRL_ABORT  = 3;
    localparam int unsigned CTRL_BUSY   = 8;
    localparam int unsigned CTRL_DONE   = 9;
    localparam int unsigned CTRL_ERR    = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POLL,
        ST_POLL_GAP,
        ST_RD_SRC,
        ST_WR_DST,
        ST_NEXT,
        ST_DONE,
        ST_ERR
    } dma_state_e;

endpackage

// File: rtl/neosd_dma_if.sv
// Classic single-beat Wishbone bus bundle; used both for the DMA register
// slave port and for the DMA master port.
interface neosd_dma_if;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [31:0] rdat;
    logic        we;
    logic [3:0]  sel;
    logic        cyc;
    logic        stb;
    logic        ack;

    modport master (output adr, wdat, we, sel, cyc, stb, input  ack, rdat);
    modport slave  (input  adr, wdat, we, sel, cyc, stb, output ack, rdat);
endinterface

// File: rtl/neosd_dma_wbm.sv
// Single-beat Wishbone master. A beat is launched on req_i while idle, the
// bus signals are held until ack, and a one-cycle done_o/err_o pulse reports
// completion or timeout. No new beat is accepted in the pulse cycle, which
// guarantees an idle bus cycle between beats.
module neosd_dma_wbm #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          req_i,
    input  logic          we_i,
    input  logic [31:0]   adr_i,
    input  logic [31:0]   wdat_i,
    output logic          done_o,
    output logic          err_o,
    output logic [31:0]   rdat_o,
    neosd_dma_if.master   bus
);
    localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

    logic          cyc_q;
    logic          we_q;
    logic [31:0]   adr_q;
    logic [31:0]   wdat_q;
    logic [31:0]   rdat_q;
    logic [CW-1:0] cnt_q;
    logic          done_q;
    logic          err_q;

    // Beat sequencing, timeout counting and read-data capture
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            cyc_q  <= 1'b0;
            we_q   <= 1'b0;
            adr_q  <= '0;
            wdat_q <= '0;
            rdat_q <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            // NOTE: pulses default low every cycle and are overridden below; all state uses <=.
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (cyc_q) begin
                if (bus.ack || cnt_q == CNT_MAX) begin
                    cyc_q  <= 1'b0;
                    we_q   <= 1'b0;
                    adr_q  <= '0;
                    wdat_q <= '0;
                    done_q <= bus.ack;
                    err_q  <= ~bus.ack;
                    if (bus.ack) rdat_q <= bus.rdat;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else if (req_i && !done_q && !err_q) begin
                cyc_q  <= 1'b1;
                we_q   <= we_i;
                adr_q  <= adr_i;
                wdat_q <= wdat_i;
                cnt_q  <= '0;
            end
        end
    end

    assign bus.cyc  = cyc_q;
    assign bus.stb  = cyc_q;
    assign bus.we   = we_q;
    assign bus.adr  = adr_q;
    assign bus.wdat = wdat_q;
    assign bus.sel  = 4'hF;
    assign done_o   = done_q;
    assign err_o    = err_q;
    assign rdat_o   = rdat_q;
endmodule

// File: rtl/neosd_dma.sv
// Word-granular DMA engine between system memory and the neosd DATA register.
// Holds the software-visible register file and the transfer FSM; bus beats
// are delegated to neosd_dma_wbm.
module neosd_dma import neosd_pkg::*; #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned POLL_GAP       = 4
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    neosd_dma_if.slave  s_bus,
    neosd_dma_if.master m_bus,
    output logic        irq_o
);
    dma_state_e  state_q;
    logic        busy_q, done_q, err_q, dir_q, irq_en_q, abort_q, irq_q;
    logic [31:0] mem_addr_q, base_q, data_q, s_rdat_q;
    logic [15:0] count_q;
    logic [7:0]  gap_q;
    logic        s_ack_q;

    logic        slv_rd, wr_ctrl, wr_addr, wr_count, wr_base, start_wr, abort_wr, abort_now;
    logic [31:0] rd_mux;
    logic        wb_req, wb_we, wb_done, wb_err, go_err;
    logic [31:0] wb_adr, wb_rdat;

    assign slv_rd    = s_bus.stb & ~s_bus.we;
    assign wr_ctrl   = s_bus.stb & s_bus.we & (s_bus.adr[3:0] == DMA_CTRL_OFF);
    assign wr_addr   = s_bus.stb & s_bus.we & (s_bus.adr[3:0] == DMA_ADDR_OFF);
    assign wr_count  = s_bus.stb & s_bus.we & (s_bus.adr[3:0] == DMA_COUNT_OFF);
    assign wr_base   = s_bus.stb & s_bus.we & (s_bus.adr[3:0] == DMA_BASE_OFF);
    assign start_wr  = wr_ctrl & s_bus.wdat[CTRL_START];
    assign abort_wr  = wr_ctrl & s_bus.wdat[CTRL_ABORT];
    assign abort_now = abort_q | (abort_wr & busy_q);

    // Register read mux, bus request generation and abort/timeout decision
    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        rd_mux = '0;
        wb_req = 1'b0;
        wb_we  = 1'b0;
        wb_adr = '0;
        go_err = 1'b0;
        case (s_bus.adr[3:0])
            DMA_CTRL_OFF: begin
                rd_mux[CTRL_DIR]    = dir_q;
                rd_mux[CTRL_IRQ_EN] = irq_en_q;
                rd_mux[CTRL_BUSY]   = busy_q;
                rd_mux[CTRL_DONE]   = done_q;
                rd_mux[CTRL_ERR]    = err_q;
            end
            DMA_ADDR_OFF:  rd_mux = mem_addr_q;
            DMA_COUNT_OFF: rd_mux = {16'h0000, count_q};
            DMA_BASE_OFF:  rd_mux = base_q;
            default:       rd_mux = '0;
        endcase
        case (state_q)
            ST_POLL: begin
                wb_req = 1'b1;
                wb_adr = base_q + NEOSD_CTRL_OFF;
                go_err = wb_err | (wb_done & abort_now);
            end
            ST_RD_SRC: begin
                wb_req = 1'b1;
                wb_adr = dir_q ? mem_addr_q : base_q + NEOSD_DATA_OFF;
                go_err = wb_err | (wb_done & abort_now);
            end
            ST_WR_DST: begin
                wb_req = 1'b1;
                wb_we  = 1'b1;
                wb_adr = dir_q ? base_q + NEOSD_DATA_OFF : mem_addr_q;
                go_err = wb_err | (wb_done & abort_now);
            end
            ST_POLL_GAP: go_err = abort_now;
            ST_NEXT:     go_err = abort_now & (count_q != 16'd1);
            default:     go_err = 1'b0;
        endcase
    end

    neosd_dma_wbm #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wbm (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .req_i  (wb_req),
        .we_i   (wb_we),
        .adr_i  (wb_adr),
        .wdat_i (data_q),
        .done_o (wb_done),
        .err_o  (wb_err),
        .rdat_o (wb_rdat),
        .bus    (m_bus)
    );

    // Register file, slave response and transfer FSM
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            dir_q      <= 1'b0;
            irq_en_q   <= 1'b0;
            abort_q    <= 1'b0;
            irq_q      <= 1'b0;
            mem_addr_q <= '0;
            base_q     <= '0;
            data_q     <= '0;
            count_q    <= '0;
            gap_q      <= '0;
            s_ack_q    <= 1'b0;
            s_rdat_q   <= '0;
        end else begin
            s_ack_q  <= s_bus.stb;
            s_rdat_q <= slv_rd ? rd_mux : 32'h0;
            irq_q    <= (done_q | err_q) & irq_en_q;

            // Software writes; hardware sets further down take priority over W1C
            if (wr_ctrl) begin
                dir_q    <= s_bus.wdat[CTRL_DIR];
                irq_en_q <= s_bus.wdat[CTRL_IRQ_EN];
                if (s_bus.wdat[CTRL_DONE]) done_q <= 1'b0;
                if (s_bus.wdat[CTRL_ERR])  err_q  <= 1'b0;
            end
            if (!busy_q) begin
                if (wr_addr)  mem_addr_q <= {s_bus.wdat[31:2], 2'b00};
                if (wr_count) count_q    <= s_bus.wdat[15:0];
                if (wr_base)  base_q     <= s_bus.wdat;
            end
            if (abort_wr && busy_q) abort_q <= 1'b1;
            if (state_q == ST_NEXT) begin
                mem_addr_q <= mem_addr_q + 32'd4;
                count_q    <= count_q - 16'd1;
            end

            if (go_err) begin
                err_q   <= 1'b1;
                busy_q  <= 1'b0;
                abort_q <= 1'b0;
                state_q <= ST_ERR;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start_wr && !abort_wr) begin
                            err_q <= 1'b0;
                            if (count_q == 16'd0) begin
                                done_q  <= 1'b1;
                                state_q <= ST_DONE;
                            end else begin
                                done_q  <= 1'b0;
                                busy_q  <= 1'b1;
                                abort_q <= 1'b0;
                                state_q <= ST_POLL;
                            end
                        end
                    end
                    ST_POLL: begin
                        if (wb_done) begin
                            gap_q   <= '0;
                            state_q <= wb_rdat[NEOSD_FLAG_BIT] ? ST_RD_SRC : ST_POLL_GAP;
                        end
                    end
                    ST_POLL_GAP: begin
                        if (gap_q == 8'(POLL_GAP - 1)) state_q <= ST_POLL;
                        else                           gap_q   <= gap_q + 8'd1;
                    end
                    ST_RD_SRC: begin
                        if (wb_done) begin
                            data_q  <= wb_rdat;
                            state_q <= ST_WR_DST;
                        end
                    end
                    ST_WR_DST: if (wb_done) state_q <= ST_NEXT;
                    ST_NEXT: begin
                        if (count_q == 16'd1) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= ST_DONE;
                        end else begin
                            state_q <= ST_POLL;
                        end
                    end
                    ST_DONE: state_q <= ST_IDLE;
                    ST_ERR:  state_q <= ST_IDLE;
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign s_bus.ack  = s_ack_q;
    assign s_bus.rdat = s_rdat_q;
    assign irq_o      = irq_q;
endmodule

// File: tb/tb_neosd_dma.sv
// Directed bench for neosd_dma: a card/memory bus model answers the master
// port while register accesses drive the slave port.
module tb_neosd_dma;
    localparam logic [31:0] SD_BASE = 32'h8000_0000;
    localparam logic [3:0]  R_CTRL  = 4'h0;
    localparam logic [3:0]  R_ADDR  = 4'h4;
    localparam logic [3:0]  R_COUNT = 4'h8;
    localparam logic [3:0]  R_BASE  = 4'hC;

    logic clk_i = 1'b0;
    logic rstn_i;
    logic irq_o;
    always #5 clk_i = ~clk_i;

    neosd_dma_if s_if ();
    neosd_dma_if m_if ();

    neosd_dma #(.TIMEOUT_CYCLES(16), .POLL_GAP(4)) dut (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .s_bus  (s_if),
        .m_bus  (m_if),
        .irq_o  (irq_o)
    );

    int total = 0;
    int bad   = 0;

    // bus model state (written only by the model process)
    int          polls = 0;
    int          card_wr_cnt = 0;
    int          cyc_cnt = 0;
    int          stb_run = 0;
    int          last_run = 0;
    logic [31:0] card_rd_idx = 32'h0;
    logic [31:0] card_wr_last = 32'h0;
    logic        last_flag = 1'b0;
    logic        wr_flag = 1'b0;
    logic [31:0] mem [logic [31:0]];
    // model controls (written only by the stimulus process)
    int          flag_after;
    logic        mem_silent;

    function automatic logic [31:0] mem_init(input logic [31:0] a);
        return (a == 32'h0000_2000) ? 32'hDEAD_BEEF : ~a;
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : mem_init(a);
    endfunction

    // Card + memory slave model with registered ack
    always @(posedge clk_i) begin
        m_if.ack <= 1'b0;
        if (m_if.cyc) cyc_cnt++;
        if (m_if.stb) stb_run++;
        else if (stb_run != 0) begin last_run = stb_run; stb_run = 0; end
        if (m_if.cyc && m_if.stb && !m_if.ack) begin
            if (m_if.adr >= SD_BASE && m_if.adr < SD_BASE + 32'h20) begin
                m_if.ack <= 1'b1;
                if (m_if.adr == SD_BASE) begin
                    polls++;
                    last_flag = (polls >= flag_after);
                    m_if.rdat <= last_flag ? 32'h0002_0000 : 32'h0;
                end else if (m_if.adr == SD_BASE + 32'h14) begin
                    if (m_if.we) begin
                        card_wr_cnt++;
                        card_wr_last = m_if.wdat;
                        wr_flag = last_flag;
                    end else begin
                        card_rd_idx = card_rd_idx + 32'd1;
                        m_if.rdat <= 32'hA5A5_0000 + card_rd_idx;
                    end
                end
            end else if (!mem_silent) begin
                m_if.ack <= 1'b1;
                if (m_if.we) mem[m_if.adr] = m_if.wdat;
                else m_if.rdat <= mem_rd(m_if.adr);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    // register accesses start and end at a falling edge
    task automatic reg_wr(input logic [3:0] off, input logic [31:0] d);
        s_if.stb = 1'b1; s_if.we = 1'b1; s_if.adr = {28'h0, off}; s_if.wdat = d;
        @(negedge clk_i);
        s_if.stb = 1'b0; s_if.we = 1'b0;
    endtask

    task automatic reg_rd(input logic [3:0] off, output logic [31:0] d);
        s_if.stb = 1'b1; s_if.we = 1'b0; s_if.adr = {28'h0, off};
        @(negedge clk_i);
        s_if.stb = 1'b0;
        d = s_if.ack ? s_if.rdat : 32'hBAD0_BAD0;
    endtask

    task automatic check_reg(input string tag, input logic [3:0] off, input logic [31:0] exp);
        logic [31:0] v;
        reg_rd(off, v);
        check(tag, v, exp);
    endtask

    task automatic wait_idle(input string tag);
        logic [31:0] v;
        int n;
        v = 32'h100;
        n = 0;
        while (v[8] && n < 3000) begin
            reg_rd(R_CTRL, v);
            n++;
        end
        check(tag, {31'b0, v[8]}, 32'h0);
    endtask

    initial begin
        int w0, c0, n;
        flag_after = 3;
        mem_silent = 1'b0;
        rstn_i = 1'b0;
        s_if.stb = 1'b0; s_if.we = 1'b0; s_if.adr = '0; s_if.wdat = '0;
        s_if.cyc = 1'b0; s_if.sel = 4'h0;
        repeat (3) @(negedge clk_i);
        rstn_i = 1'b1;

        // reset state
        check("rst_irq", {31'b0, irq_o}, 32'h0);
        check("rst_cyc", {31'b0, m_if.cyc}, 32'h0);
        check("rst_sack", {31'b0, s_if.ack}, 32'h0);
        check_reg("rst_ctrl", R_CTRL, 32'h0);
        check_reg("rst_addr", R_ADDR, 32'h0);
        check_reg("rst_count", R_COUNT, 32'h0);
        check_reg("rst_base", R_BASE, 32'h0);

        // card -> memory, two words, flag on 3rd poll
        reg_wr(R_BASE, SD_BASE);
        reg_wr(R_ADDR, 32'h0000_1003);
        reg_wr(R_COUNT, 32'd2);
        reg_wr(R_CTRL, 32'h1);
        wait_idle("t1_idle");
        check("t1_mem0", mem_rd(32'h1000), 32'hA5A5_0001);
        check("t1_mem1", mem_rd(32'h1004), 32'hA5A5_0002);
        check("t1_polls", 32'(polls), 32'd4);
        check_reg("t1_ctrl", R_CTRL, 32'h0000_0200);
        check_reg("t1_count", R_COUNT, 32'h0);
        check_reg("t1_addr", R_ADDR, 32'h0000_1008);

        // memory -> card, one word
        reg_wr(R_CTRL, 32'h200);
        check_reg("t2_w1c", R_CTRL, 32'h0);
        flag_after = 0;
        reg_wr(R_ADDR, 32'h0000_2000);
        reg_wr(R_COUNT, 32'd1);
        w0 = card_wr_cnt;
        reg_wr(R_CTRL, 32'h3);
        wait_idle("t2_idle");
        check("t2_wrcnt", 32'(card_wr_cnt - w0), 32'd1);
        check("t2_wrdat", card_wr_last, 32'hDEAD_BEEF);
        check("t2_flag", {31'b0, wr_flag}, 32'h1);
        check_reg("t2_ctrl", R_CTRL, 32'h0000_0202);
        check_reg("t2_addr", R_ADDR, 32'h0000_2004);

        // COUNT = 0: DONE next cycle, no bus cycle
        c0 = cyc_cnt;
        reg_wr(R_CTRL, 32'h201);
        check_reg("t3_ctrl", R_CTRL, 32'h0000_0200);
        repeat (4) @(negedge clk_i);
        check("t3_nocyc", 32'(cyc_cnt - c0), 32'd0);

        // memory never acks: timeout after 16 cycles
        reg_wr(R_CTRL, 32'h204);
        mem_silent = 1'b1;
        reg_wr(R_ADDR, 32'h0000_3000);
        reg_wr(R_COUNT, 32'd1);
        reg_wr(R_CTRL, 32'h7);
        wait_idle("t4_idle");
        check("t4_stbrun", 32'(last_run), 32'd16);
        check_reg("t4_ctrl", R_CTRL, 32'h0000_0406);
        check("t4_irq", {31'b0, irq_o}, 32'h1);
        check_reg("t4_count", R_COUNT, 32'd1);
        mem_silent = 1'b0;
        reg_wr(R_CTRL, 32'h400);
        @(negedge clk_i);
        check("t4_irq_clr", {31'b0, irq_o}, 32'h0);

        // ABORT in POLL_GAP; writes while BUSY ignored
        flag_after = 1000000;
        reg_wr(R_ADDR, 32'h0000_4000);
        reg_wr(R_COUNT, 32'd5);
        reg_wr(R_CTRL, 32'h1);
        check_reg("t5_busy", R_CTRL, 32'h0000_0100);
        reg_wr(R_CTRL, 32'h1);
        reg_wr(R_COUNT, 32'd7);
        n = 0;
        while (!m_if.ack && n < 100) begin @(negedge clk_i); n++; end
        check("t5_pollack", {31'b0, m_if.ack}, 32'h1);
        repeat (2) @(negedge clk_i);
        reg_wr(R_CTRL, 32'h8);
        check_reg("t5_ctrl", R_CTRL, 32'h0000_0400);
        check_reg("t5_count", R_COUNT, 32'd5);
        check_reg("t5_addr", R_ADDR, 32'h0000_4000);

        // reset mid-WR_DST
        reg_wr(R_CTRL, 32'h400);
        flag_after = 0;
        reg_wr(R_ADDR, 32'h0000_5000);
        reg_wr(R_COUNT, 32'd3);
        reg_wr(R_CTRL, 32'h1);
        n = 0;
        while (!(m_if.cyc && m_if.we) && n < 200) begin @(negedge clk_i); n++; end
        check("t6_inwr", {31'b0, m_if.cyc & m_if.we}, 32'h1);
        rstn_i = 1'b0;
        @(negedge clk_i);
        rstn_i = 1'b1;
        check("t6_cyc", {31'b0, m_if.cyc}, 32'h0);
        check("t6_stb", {31'b0, m_if.stb}, 32'h0);
        check("t6_we", {31'b0, m_if.we}, 32'h0);
        check("t6_adr", m_if.adr, 32'h0);
        check("t6_dat", m_if.wdat, 32'h0);
        check("t6_irq", {31'b0, irq_o}, 32'h0);
        check("t6_sack", {31'b0, s_if.ack}, 32'h0);
        check_reg("t6_ctrl", R_CTRL, 32'h0);
        check_reg("t6_addr", R_ADDR, 32'h0);
        check_reg("t6_count", R_COUNT, 32'h0);
        check_reg("t6_base", R_BASE, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
